// File: rtl/vrased_log_reader.sv
// Drains the violation-log RAM as a header word plus 16-bit entry words on a valid/ready stream.
// One RAM read per entry; out_valid/out_data are registered and hold while out_ready is low.
module vrased_log_reader #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 38,
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  drain_req,
  input  logic [ADDR_WIDTH:0]   log_count,
  output logic                  re,
  output logic [15:0]           rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  clr_ram,
  output logic [15:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int WORDS = (DATA_WIDTH + 15) / 16;
  localparam int EW    = WORDS * 16;
  localparam int WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [WIW-1:0]      LAST_W = WIW'(WORDS - 1);

  typedef enum logic [2:0] {IDLE, HDR, RD, CAP, WRD, CLR, FIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   cnt, ptr, cnt_sat, ptr_nxt, cnt_m1;
  logic [WIW-1:0]        widx;
  logic [EW-1:0]         entry, rd_pad, entry_sh;

  assign cnt_sat  = (log_count > DEPTH) ? DEPTH : log_count;
  assign ptr_nxt  = ptr + ONE;
  assign cnt_m1   = cnt - ONE;
  assign rd_pad   = EW'(rd_data);
  // The entry register shifts down one word per handshake, so word 0 is always at the bottom.
  assign entry_sh = entry >> 16;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      widx      <= '0;
      entry     <= '0;
      re        <= 1'b0;
      rd_addr   <= '0;
      clr_ram   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      re      <= 1'b0;
      clr_ram <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (drain_req) begin
            cnt       <= cnt_sat;
            ptr       <= '0;
            out_data  <= {1'b1, 15'(cnt_sat)};
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= HDR;
          end
        end
        HDR: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cnt != '0) begin
              re      <= 1'b1;
              rd_addr <= 16'(ptr);
              state   <= RD;
            end else if (CLEAR_ON_DONE) begin
              clr_ram <= 1'b1;
              state   <= CLR;
            end else begin
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          entry     <= rd_pad;
          widx      <= '0;
          out_data  <= rd_pad[15:0];
          out_valid <= 1'b1;
          state     <= WRD;
        end
        WRD: begin
          if (out_ready) begin
            if (widx != LAST_W) begin
              widx     <= widx + WIW'(1);
              entry    <= entry_sh;
              out_data <= entry_sh[15:0];
            end else begin
              out_valid <= 1'b0;
              if (ptr == cnt_m1) begin
                if (CLEAR_ON_DONE) begin
                  clr_ram <= 1'b1;
                  state   <= CLR;
                end else begin
                  done  <= 1'b1;
                  state <= FIN;
                end
              end else begin
                ptr     <= ptr_nxt;
                re      <= 1'b1;
                rd_addr <= 16'(ptr_nxt);
                state   <= RD;
              end
            end
          end
        end
        CLR: begin
          done  <= 1'b1;
          state <= FIN;
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
